// File: rtl/serpent_key_schedule.sv
// Serpent key expansion: padded user key -> 33 bitsliced round keys K0..K32, one per handshake.
// Build option SERPENT_KS_ZEROIZE_EN clears window/round_key after use and masks round_key when idle.
module serpent_key_schedule #(
  parameter logic [31:0] PHI      = 32'h9E3779B9,
  parameter int          NUM_KEYS = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [1:0]   key_len,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] round_key,
  output logic [5:0]   rk_idx,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, GEN, HOLD} state_t;

  state_t              state, state_nxt;
  logic [7:0][31:0]    win;
  logic [11:0][31:0]   ext;
  logic [5:0]          n;
  logic [127:0]        rk_q, rk_next;
  logic [255:0]        key_pad;
  logic [31:0]         ibase;
  logic [2:0]          sel;
  logic [3:0]          nib;
  logic                start_acc, hs, last;

  function automatic logic [31:0] rotl11(input logic [31:0] x);
    return {x[20:0], x[31:21]};
  endfunction

  // Table t holds entry x at bits [4x+3:4x].
  function automatic logic [3:0] sbox(input logic [2:0] s, input logic [3:0] x);
    logic [63:0] t;
    case (s)
      3'd0:    t = 64'hC90724DEB56A1F83;
      3'd1:    t = 64'h43D68EB1A50972CF;
      3'd2:    t = 64'h25B04E1DFAC39768;
      3'd3:    t = 64'hE57A421D369C8BF0;
      3'd4:    t = 64'hD7E9A4526B0C38F1;
      3'd5:    t = 64'h176D8E30C9A4B25F;
      3'd6:    t = 64'h0A3DF19EB6485C27;
      default: t = 64'h6539AC47B28E0FD1;
    endcase
    return t[{x, 2'b00} +: 4];
  endfunction

  assign start_acc = (state == IDLE) && start;
  assign hs        = (state == HOLD) && rk_valid && rk_ready;
  assign last      = (n == 6'(NUM_KEYS - 1));
  assign ibase     = {24'd0, n, 2'b00};

  always_comb begin
    key_pad = key;
    case (key_len)
      2'd0:    key_pad = {127'd0, 1'b1, key[127:0]};
      2'd1:    key_pad = {63'd0, 1'b1, key[191:0]};
      default: ;
    endcase
  end

  // ext[0..7] = w(i-8)..w(i-1); ext[8..11] = the four new prekey words.
  always_comb begin
    ext      = '0;
    ext[7:0] = win;
    for (int k = 0; k < 4; k++)
      ext[8+k] = rotl11(ext[k] ^ ext[k+3] ^ ext[k+5] ^ ext[k+7] ^ PHI ^ (ibase + 32'(k)));
  end

  always_comb begin
    sel     = 3'd3 - n[2:0];
    rk_next = '0;
    nib     = '0;
    for (int j = 0; j < 32; j++) begin
      nib            = sbox(sel, {ext[11][j], ext[10][j], ext[9][j], ext[8][j]});
      rk_next[j]     = nib[0];
      rk_next[32+j]  = nib[1];
      rk_next[64+j]  = nib[2];
      rk_next[96+j]  = nib[3];
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = GEN;
      GEN:     state_nxt = HOLD;
      HOLD:    if (rk_valid && rk_ready) state_nxt = last ? IDLE : GEN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win      <= '0;
      n        <= '0;
      rk_q     <= '0;
      rk_idx   <= '0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_acc) begin
        win  <= key_pad;
        n    <= '0;
        busy <= 1'b1;
`ifdef SERPENT_KS_ZEROIZE_EN
        rk_q <= '0;
`endif
      end
      if (state == GEN) begin
        rk_q     <= rk_next;
        rk_idx   <= n;
        rk_valid <= 1'b1;
        win      <= ext[11:4];
      end
      if (hs) begin
        rk_valid <= 1'b0;
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
`ifdef SERPENT_KS_ZEROIZE_EN
          win  <= '0;
          rk_q <= '0;
`endif
        end else begin
          n <= n + 6'd1;
        end
      end
    end
  end

`ifdef SERPENT_KS_ZEROIZE_EN
  assign round_key = rk_valid ? rk_q : '0;
`else
  assign round_key = rk_q;
`endif

endmodule

// File: tb/tb_serpent_key_schedule.sv
// Randomized bench for serpent_key_schedule against a prekey-array reference model.
module tb_serpent_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [255:0] key;
  logic [1:0]   key_len;
  logic         busy, rk_valid, rk_ready, done;
  logic [127:0] round_key;
  logic [5:0]   rk_idx;

  int errors = 0;
  int checks = 0;

  localparam bit [31:0] PHI = 32'h9E3779B9;

  int unsigned sbt [8][16] = '{
    '{ 3, 8,15, 1,10, 6, 5,11,14,13, 4, 2, 7, 0, 9,12},
    '{15,12, 2, 7, 9, 0, 5,10, 1,11,14, 8, 6,13, 3, 4},
    '{ 8, 6, 7, 9, 3,12,10,15,13, 1,14, 4, 0,11, 5, 2},
    '{ 0,15,11, 8,12, 9, 6, 3,13, 1, 2, 4,10, 7, 5,14},
    '{ 1,15, 8, 3,12, 0,11, 6, 2, 5, 4,10, 9,14, 7,13},
    '{15, 5, 2,11, 4,10, 9,12, 0, 3,14, 8,13, 6, 7, 1},
    '{ 7, 2,12, 5, 8, 4, 6,11,14, 9, 1,15,13, 3,10, 0},
    '{ 1,13,15, 0,14, 8, 2,11, 7, 4,12,10, 9, 3, 5, 6}
  };

  logic [127:0] mk [33];

  serpent_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .key_len(key_len),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .round_key(round_key), .rk_idx(rk_idx), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Whole prekey array w(-8)..w(131) at offset 8, then bitsliced keys.
  task automatic build_model(input logic [255:0] k, input logic [1:0] len);
    logic [255:0] p;
    bit [31:0]    w [140];
    bit [31:0]    t;
    int unsigned  x, y, s;
    p = k;
    if (len == 2'd0) begin p[255:128] = '0; p[128] = 1'b1; end
    else if (len == 2'd1) begin p[255:192] = '0; p[192] = 1'b1; end
    for (int j = 0; j < 8; j++) w[j] = p[32*j +: 32];
    for (int i = 0; i < 132; i++) begin
      t = w[i] ^ w[i+3] ^ w[i+5] ^ w[i+7] ^ PHI ^ i;
      w[i+8] = (t << 11) | (t >> 21);
    end
    for (int n = 0; n < 33; n++) begin
      s = (35 - n) % 8;
      mk[n] = '0;
      for (int j = 0; j < 32; j++) begin
        x = w[8+4*n][j] + 2*w[9+4*n][j] + 4*w[10+4*n][j] + 8*w[11+4*n][j];
        y = sbt[s][x];
        mk[n][j]      = y[0];
        mk[n][32+j]   = y[1];
        mk[n][64+j]   = y[2];
        mk[n][96+j]   = y[3];
      end
    end
  endtask

  // mode 0: ready high; 1: 5-cycle stall at idx 7; 2: random ready; 3: ready high + start at idx 10
  task automatic expand(input logic [255:0] k, input logic [1:0] len, input int mode);
    int   cyc, got, hold;
    bit   fin, bp_done, inj, first, prev_stall;
    logic [127:0] prev_rk;
    logic [5:0]   prev_idx;
    build_model(k, len);
    key = k; key_len = len; start = 1'b1; rk_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; key = ~k; key_len = ~len;
    cyc = 1; got = 0; hold = 0;
    fin = 0; bp_done = 0; inj = 0; first = 0; prev_stall = 0;
    prev_rk = '0; prev_idx = '0;
    chk("done_pulse_width", {127'd0, done}, 128'd0);
    chk("busy_after_start", {127'd0, busy}, 128'd1);
    while (!fin && cyc < 400) begin
      if (prev_stall) begin
        chk("stall_valid", {127'd0, rk_valid}, 128'd1);
        chk("stall_key", round_key, prev_rk);
        chk("stall_idx", {122'd0, rk_idx}, {122'd0, prev_idx});
      end
      if (done) begin
        fin = 1;
        if (mode == 0 || mode == 3) chk("done_latency", 128'(cyc), 128'd67);
        chk("key_count", 128'(got), 128'd33);
        chk("busy_at_done", {127'd0, busy}, 128'd0);
        chk("valid_at_done", {127'd0, rk_valid}, 128'd0);
`ifdef SERPENT_KS_ZEROIZE_EN
        chk("rk_after_done", round_key, 128'd0);
`else
        chk("rk_after_done", round_key, mk[32]);
`endif
      end else begin
        if (rk_valid && !first) begin
          first = 1;
          chk("first_valid_latency", 128'(cyc), 128'd2);
        end
        if (mode == 1 && rk_valid && rk_idx == 6'd7 && !bp_done) begin
          hold = 5; bp_done = 1;
        end
        if (hold > 0) begin rk_ready = 1'b0; hold--; end
        else if (mode == 2) rk_ready = 1'($urandom_range(0, 1));
        else rk_ready = 1'b1;
        if (mode == 3 && rk_valid && rk_idx == 6'd10 && !inj) begin
          start = 1'b1; key = {8{$urandom}}; key_len = 2'($urandom_range(0, 3)); inj = 1;
        end else start = 1'b0;
        if (rk_valid && rk_ready) begin
          chk($sformatf("idx_%0d", got), {122'd0, rk_idx}, 128'(got));
          chk($sformatf("key_%0d", got), round_key, mk[got]);
          got++;
        end
        prev_stall = rk_valid && !rk_ready;
        prev_rk = round_key; prev_idx = rk_idx;
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0; rk_ready = 1'b0;
    if (!fin) chk("expand_timeout", 128'd0, 128'd1);
  endtask

  task automatic reset_midway();
    int  cyc;
    logic [255:0] k;
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    key = k; key_len = 2'd2; start = 1'b1; rk_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc = 0;
    while (!(rk_valid && rk_idx == 6'd20) && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    chk("reach_idx20", {127'd0, rk_valid}, 128'd1);
    rk_ready = 1'b0;
    rst_n = 1'b0; #1;
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_valid", {127'd0, rk_valid}, 128'd0);
    chk("rst_idx", {122'd0, rk_idx}, 128'd0);
    chk("rst_key", round_key, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rk_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_valid", {127'd0, rk_valid}, 128'd0);
    chk("post_rst_busy", {127'd0, busy}, 128'd0);
    rk_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; key = '0; key_len = 2'd0; rk_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {127'd0, busy}, 128'd0);
    chk("reset_valid", {127'd0, rk_valid}, 128'd0);
    chk("reset_done", {127'd0, done}, 128'd0);
    chk("reset_idx", {122'd0, rk_idx}, 128'd0);
    chk("reset_key", round_key, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    expand('0, 2'd2, 0);
    expand('0, 2'd0, 0);
    expand('0, 2'd1, 0);
    expand({8{$urandom}}, 2'($urandom_range(0, 3)), 1);
    expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 2'd2, 3);
    reset_midway();
    expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 2'd3, 0);
    for (int r = 0; r < 4; r++)
      expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
             2'($urandom_range(0, 3)), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serpent_key_schedule.md
Name: serpent_key_schedule

Overview:
- Upstream stage of the Serpent encryption datapath. Expands a user key of up to 256 bits into the 33 128-bit round keys K0..K32.
- Emits one round key per valid/ready handshake, in order K0 to K32.
- K0..K31 feed enc_round_0..7 in rotation. K31 and K32 feed final_round as round_key1 and round_key2.
- Sequential: an 8-word prekey sliding window advances by 4 words per produced key.

Parameters:
- PHI, 32'h9E3779B9, golden-ratio constant in the prekey recurrence.
- NUM_KEYS, 33, number of round keys emitted per expansion. Fixed for Serpent; must not be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin expansion. Sampled only in IDLE.
- key  in  256  user key. key[31:0] is prekey word w(-8). Sampled on accepted start.
- key_len  in  2  0 = 128-bit, 1 = 192-bit, 2 = 256-bit. 3 is treated as 256-bit.
- busy  out  1  high from accepted start until the final handshake completes.
- rk_valid  out  1  round_key is valid.
- rk_ready  in  1  consumer accepts round_key.
- round_key  out  128  {X3,X2,X1,X0}. X0 occupies [31:0].
- rk_idx  out  6  index 0..32 of the presented key.
- done  out  1  one-cycle pulse in the cycle after K32 is accepted.

Behaviour:
- Reset (async, rst_n = 0): state = IDLE. busy, rk_valid, done = 0. round_key = 0, rk_idx = 0. Window registers = 0.
- Padding on start: keys shorter than 256 bits get a single 1 bit directly above the MSB of the key, then zeros.
  - 128-bit: bit 128 = 1, bits above 128 = 0.
  - 192-bit: bit 192 = 1, bits above 192 = 0.
- Prekey recurrence: w(i) = rotl11(w(i-8) ^ w(i-5) ^ w(i-3) ^ w(i-1) ^ PHI ^ i), with i a 32-bit value, for i = 0..131.
- Each cycle computes the 4 words w(4n)..w(4n+3) as one combinational chain from the window.
- Round key n is formed by bitslicing those 4 words through S-box S((3-n) mod 8):
  - For each bit j in 0..31, the nibble {w(4n+3)[j], w(4n+2)[j], w(4n+1)[j], w(4n)[j]} passes through the S-box.
  - Output nibble bits 0..3 go to X0..X3 bit j.
  - S-box tables are identical to those in S0_32..S7_32, implemented combinationally inside this block.
- FSM:
  - IDLE: on start, load the window with the padded key, set n = 0, go to GEN.
  - GEN (1 cycle): register round_key = K(n), rk_idx = n, rk_valid = 1; shift 4 new words into the window; go to HOLD.
  - HOLD: round_key and rk_idx stay stable while rk_valid = 1 and rk_ready = 0.
    - On rk_valid & rk_ready with n < 32: n <= n+1, rk_valid <= 0, go to GEN.
    - With n = 32: rk_valid <= 0, busy <= 0, done <= 1 next cycle, go to IDLE.
- Latency: start accepted at cycle T gives rk_valid = 1 at T+2. With rk_ready tied high, keys are spaced every 2 cycles and a full expansion takes 67 cycles from start to done.
- start while busy is ignored; the key is not re-sampled. start in the same cycle as done is accepted.
- rk_ready while rk_valid = 0 has no effect.
- Deassertion of rst_n mid-expansion aborts immediately to IDLE with all outputs at their reset values. No partial key is presented after reset.
- Window index i wraps nowhere: n saturates at 32, and the i input to the XOR never exceeds 131.

Optional Feature:
- SERPENT_KS_ZEROIZE_EN defined:
  - On the done cycle, and on any accepted start, the window registers and round_key are cleared to 0 before reuse.
  - round_key reads 0 whenever rk_valid = 0.
- Undefined: the window and round_key retain their last values after completion. Area-minimal variant.

Test Plan:
- 256-bit key 0, rk_ready = 1: all 33 keys match the golden C model. done pulses exactly 67 cycles after start. rk_idx sequence is 0..32.
- 128-bit key 0: padding makes w(-4) = 0x00000001. Internal w(0) = 0xBBCDCCF1. K0..K32 match the model. The 192-bit key 0 also matches the model.
- Backpressure: rk_ready low for 5 cycles at rk_idx = 7. round_key and rk_idx remain stable, no key is skipped or duplicated, and the remaining keys match the model.
- start pulsed during busy (rk_idx = 10) with a different key: output sequence unchanged, no restart.
- rst_n low at rk_idx = 20 then released: busy = 0 and rk_valid = 0 immediately. A fresh start produces K0 correctly.
- Zeroize build: round_key = 0 after done. Non-zeroize build: round_key still equals K32 after done.
